// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with configurable wait states and a combinational stall.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with an err pulse.
module dmem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_enable,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              err
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                r_state;
  logic [3:0]            r_cnt;
  logic                  r_op_read;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_rdata_valid;
  logic                  r_err;
  logic [DATA_W-1:0]     r_mem [Depth];

  logic                  w_req;
  logic                  w_valid;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_start;
  logic                  w_idle_acc;
  logic                  w_access;
  logic                  w_acc_read;
  logic [DEPTH_LOG2-1:0] w_acc_idx;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic                  w_unused;

  assign w_req     = ~mem_enable;
  assign w_valid   = w_req & (mem_read ^ mem_write);
  assign w_illegal = w_req & ~(mem_read ^ mem_write);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misaligned = w_valid & (addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_start    = (r_state == StIdle) & w_valid & ~w_misaligned;
  // With zero wait states the access commits on the same edge that accepts the request.
  assign w_idle_acc = w_start & (WAIT_CYCLES == 0);
  assign w_access   = rst_n & (w_idle_acc | ((r_state == StWait) & (r_cnt == 4'd0)));

  assign w_acc_read  = w_idle_acc ? ~mem_read : r_op_read;
  assign w_acc_idx   = w_idle_acc ? addr[DEPTH_LOG2+1:2] : r_idx;
  assign w_acc_wdata = w_idle_acc ? wdata : r_wdata;

  assign stall       = rst_n & (w_start | (r_state == StWait));
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign err         = r_err;

  assign w_unused = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (w_access && !w_acc_read) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= 4'd0;
      r_op_read     <= 1'b0;
      r_idx         <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
      if (w_access && w_acc_read) begin
        r_rdata       <= r_mem[w_acc_idx];
        r_rdata_valid <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          r_err <= w_illegal | w_misaligned;
          if (w_start) begin
            r_op_read <= ~mem_read;
            r_idx     <= addr[DEPTH_LOG2+1:2];
            r_wdata   <= wdata;
            if (WAIT_CYCLES == 0) begin
              r_state <= StResp;
            end else begin
              r_state <= StWait;
              r_cnt   <= CntInit;
            end
          end
        end
        StWait: begin
          if (r_cnt == 4'd0) begin
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (default parameters, WAIT_CYCLES = 2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_enable = 1'b1;
  logic        mem_read = 1'b1;
  logic        mem_write = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  int          n_valid = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model [256];

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .DEPTH_LOG2 (8),
    .WAIT_CYCLES(2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_enable (mem_enable),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .stall      (stall),
    .err        (err)
  );

  // Every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && rdata_valid) begin
      logic [31:0] exp;
      n_valid++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: rdata=%h with no read pending", rdata);
      end else begin
        exp = sb_q.pop_front();
        if (rdata !== exp) begin
          failures++;
          $display("FAIL read_data: got %h expected %h", rdata, exp);
        end
      end
    end
  end

  task automatic idle_inputs();
    mem_enable = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
  endtask

  // Issues one access starting now (just after a rising edge); returns in the following IDLE cycle.
  task automatic access(input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int n_stall);
    bit done;
    done       = 1'b0;
    n_stall    = 0;
    mem_enable = 1'b0;
    mem_read   = ~rd;
    mem_write  = rd;
    addr       = a;
    wdata      = d;
    if (rd) sb_q.push_back(model[a[9:2]]);
    else model[a[9:2]] = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n_stall++;
      @(posedge clk);
      #1;
      idle_inputs();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL access_timeout: stall still high after %0d cycles, expected release", n_stall);
    end
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 4;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    if (rdata_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", rdata_valid);
    end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sw();
    int n;
    access(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, n);
    checks += 2;
    if (n != 3) begin failures++; $display("FAIL sw_stall_len: got %0d expected 3", n); end
    if (rdata !== 32'h0) begin failures++; $display("FAIL sw_rdata: got %h expected 0", rdata); end
  endtask

  task automatic test_lw();
    int n;
    int v0;
    v0 = n_valid;
    access(1'b1, 32'h0000_0010, 32'h0, n);
    checks += 4;
    if (n != 3) begin failures++; $display("FAIL lw_stall_len: got %0d expected 3", n); end
    if (n_valid != v0 + 1) begin
      failures++; $display("FAIL lw_valid_count: got %0d expected %0d", n_valid - v0, 1);
    end
    if (rdata_valid !== 1'b0) begin
      failures++; $display("FAIL lw_valid_width: got %b expected 0", rdata_valid);
    end
    @(posedge clk);
    #1;
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL lw_hold: got %h expected deadbeef", rdata);
    end
  endtask

  task automatic test_wrap();
    int n;
    access(1'b0, 32'h0000_0400, 32'h0000_1234, n);
    access(1'b1, 32'h0000_0000, 32'h0, n);
    checks++;
    if (rdata !== 32'h0000_1234) begin
      failures++; $display("FAIL wrap_rdata: got %h expected 00001234", rdata);
    end
  endtask

  task automatic test_illegal();
    int n;
    for (int p = 0; p < 2; p++) begin
      mem_enable = 1'b0;
      mem_read   = (p == 1);
      mem_write  = (p == 1);
      addr       = 32'h0000_0010;
      wdata      = 32'hBAD0_BAD0;
      @(negedge clk);
      checks += 4;
      if (stall !== 1'b0) begin failures++; $display("FAIL illegal_stall: got %b expected 0", stall); end
      if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_early: got %b expected 0", err); end
      @(posedge clk);
      #1;
      idle_inputs();
      if (err !== 1'b1) begin failures++; $display("FAIL illegal_err: got %b expected 1", err); end
      @(posedge clk);
      #1;
      if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_width: got %b expected 0", err); end
    end
    access(1'b1, 32'h0000_0010, 32'h0, n);
  endtask

  task automatic test_reset_mid();
    int n;
    access(1'b0, 32'h0000_0020, 32'hCAFE_0020, n);
    access(1'b1, 32'h0000_0020, 32'h0, n);
    mem_enable = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    addr       = 32'h0000_0020;
    wdata      = 32'h5555_5555;
    @(negedge clk);
    checks += 4;
    if (stall !== 1'b1) begin failures++; $display("FAIL rmid_stall_start: got %b expected 1", stall); end
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    if (stall !== 1'b0) begin failures++; $display("FAIL rmid_stall_drop: got %b expected 0", stall); end
    if (rdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata: got %h expected 0", rdata); end
    if (rdata_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_valid: got %b expected 0", rdata_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 32'h0000_0020, 32'h0, n);
  endtask

  task automatic test_align();
    int n;
`ifdef DMEM_ALIGN_CHECK_EN
    int          v0;
    logic [31:0] before;
    v0         = n_valid;
    before     = rdata;
    mem_enable = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = 32'h0000_0013;
    @(negedge clk);
    checks += 4;
    if (stall !== 1'b0) begin failures++; $display("FAIL align_stall: got %b expected 0", stall); end
    @(posedge clk);
    #1;
    idle_inputs();
    if (err !== 1'b1) begin failures++; $display("FAIL align_err: got %b expected 1", err); end
    repeat (4) @(posedge clk);
    #1;
    if (n_valid != v0) begin failures++; $display("FAIL align_valid: got %0d expected 0", n_valid - v0); end
    if (rdata !== before) begin
      failures++; $display("FAIL align_rdata: got %h expected %h", rdata, before);
    end
    n = 0;
`else
    access(1'b1, 32'h0000_0013, 32'h0, n);
    checks += 2;
    if (n != 3) begin failures++; $display("FAIL align_stall_len: got %0d expected 3", n); end
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL align_rdata: got %h expected deadbeef", rdata);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    sb_q.push_back(model[4]);
    sb_q.push_back(model[4]);
    mem_enable = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = 32'h0000_0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== ((i % 4) != 3)) begin
        failures++;
        $display("FAIL b2b_stall[%0d]: got %b expected %b", i, stall, ((i % 4) != 3));
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (n_valid != v0 + 2) begin
      failures++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_sw();
    test_lw();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_align();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d pending reads expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
